// File: rtl/vga_pixel_sink.sv
// Raster timing generator and pixel output stage for the VGA path.
// The pixel counters publish the current coordinate to the drawers. The colour
// that comes back PIPE_DELAY clocks later is registered together with the
// matching delayed sync and blank.
// Optional feature macro: VGA_TEST_PATTERN_EN. When it is defined and
// testPattern is high, RGBIn is replaced by eight vertical colour bars.
module vga_pixel_sink #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter logic        SYNC_POL   = 1'b0,
  parameter int unsigned PIPE_DELAY = 2
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [7:0]  RGBIn,
  input  logic        testPattern,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic [15:0] frameCounter,
  output logic        hsync,
  output logic        vsync,
  output logic        blankN,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] HLast       = 11'(H_TOTAL - 1);
  localparam logic [10:0] VLast       = 11'(V_TOTAL - 1);
  localparam logic [10:0] HActive     = 11'(H_ACTIVE);
  localparam logic [10:0] VActive     = 11'(V_ACTIVE);
  localparam logic [10:0] HSyncStart  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HSyncEnd    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VSyncStart  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VSyncEnd    = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_cnt_q, v_cnt_q;
  logic [15:0] frame_cnt_q;
  logic        h_last, v_last;
  logic        raw_active, raw_hs, raw_vs;

  logic [PIPE_DELAY-1:0] act_pipe_q, hs_pipe_q, vs_pipe_q;

  logic [7:0] colour;
  logic       hsync_q, vsync_q, blank_n_q;
  logic [7:0] red_q, green_q, blue_q;

  assign h_last = (h_cnt_q == HLast);
  assign v_last = (v_cnt_q == VLast);

  // Raster scan: horizontal count every clock, vertical and frame count on wraps.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      frame_cnt_q <= '0;
    end else if (h_last) begin
      h_cnt_q <= '0;
      if (v_last) begin
        v_cnt_q     <= '0;
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end else begin
        v_cnt_q <= v_cnt_q + 11'd1;
      end
    end else begin
      h_cnt_q <= h_cnt_q + 11'd1;
    end
  end

  assign raw_active = (h_cnt_q < HActive) && (v_cnt_q < VActive);
  assign raw_hs     = (h_cnt_q >= HSyncStart) && (h_cnt_q < HSyncEnd);
  assign raw_vs     = (v_cnt_q >= VSyncStart) && (v_cnt_q < VSyncEnd);

  // Delay timing flags so they line up with the colour returned by the object mux.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      act_pipe_q <= '0;
      hs_pipe_q  <= '0;
      vs_pipe_q  <= '0;
    end else begin
      act_pipe_q[0] <= raw_active;
      hs_pipe_q[0]  <= raw_hs;
      vs_pipe_q[0]  <= raw_vs;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        act_pipe_q[i] <= act_pipe_q[i-1];
        hs_pipe_q[i]  <= hs_pipe_q[i-1];
        vs_pipe_q[i]  <= vs_pipe_q[i-1];
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [10:0] BarW = 11'(H_ACTIVE / 8);

  logic [10:0] x_pipe_q [PIPE_DELAY];
  logic [10:0] bar_idx;
  logic [7:0]  bar_colour;

  // Delayed column so bars are computed for the pixel whose colour arrives now.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < PIPE_DELAY; i++) x_pipe_q[i] <= '0;
    end else begin
      x_pipe_q[0] <= h_cnt_q;
      for (int i = 1; i < PIPE_DELAY; i++) x_pipe_q[i] <= x_pipe_q[i-1];
    end
  end

  // Bar colour lookup: white, yellow, cyan, green, magenta, red, blue, black.
  always_comb begin
    bar_idx = x_pipe_q[PIPE_DELAY-1] / BarW;
    case (bar_idx)
      11'd0:   bar_colour = 8'hFF;
      11'd1:   bar_colour = 8'hFC;
      11'd2:   bar_colour = 8'h1F;
      11'd3:   bar_colour = 8'h1C;
      11'd4:   bar_colour = 8'hE3;
      11'd5:   bar_colour = 8'hE0;
      11'd6:   bar_colour = 8'h03;
      default: bar_colour = 8'h00;
    endcase
  end

  assign colour = testPattern ? bar_colour : RGBIn;
`else
  logic unused_test_pattern;
  assign unused_test_pattern = testPattern;
  assign colour = RGBIn;
`endif

  // Output register: colour expansion, blanking and sync polarity in one stage.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hsync_q   <= ~SYNC_POL;
      vsync_q   <= ~SYNC_POL;
      blank_n_q <= 1'b0;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
    end else begin
      hsync_q   <= hs_pipe_q[PIPE_DELAY-1] ? SYNC_POL : ~SYNC_POL;
      vsync_q   <= vs_pipe_q[PIPE_DELAY-1] ? SYNC_POL : ~SYNC_POL;
      blank_n_q <= act_pipe_q[PIPE_DELAY-1];
      if (act_pipe_q[PIPE_DELAY-1]) begin
        red_q   <= {colour[7:5], colour[7:5], colour[7:6]};
        green_q <= {colour[4:2], colour[4:2], colour[4:3]};
        blue_q  <= {4{colour[1:0]}};
      end else begin
        red_q   <= '0;
        green_q <= '0;
        blue_q  <= '0;
      end
    end
  end

  assign pixelX       = h_cnt_q;
  assign pixelY       = v_cnt_q;
  assign frameCounter = frame_cnt_q;
  // Gated by resetN so the pulse never shows while the block is held in reset.
  assign startOfFrame = resetN && (h_cnt_q == '0) && (v_cnt_q == '0);
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign blankN       = blank_n_q;
  assign red          = red_q;
  assign green        = green_q;
  assign blue         = blue_q;

endmodule

// File: tb/tb_vga_pixel_sink.sv
// Directed bench for vga_pixel_sink using a reduced raster (24 x 10 clocks).
module tb_vga_pixel_sink;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int PD = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic TpTable = 1'b0;
`else
  // Without the feature, testPattern must be ignored, so hold it high throughout.
  localparam logic TpTable = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        resetN;
  logic [7:0]  RGBIn;
  logic        testPattern;
  logic [10:0] pixelX, pixelY;
  logic        startOfFrame;
  logic [15:0] frameCounter;
  logic        hsync, vsync, blankN;
  logic [7:0]  red, green, blue;

  always #5 clk = ~clk;

  vga_pixel_sink #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .PIPE_DELAY(PD)
  ) dut (
    .clk(clk), .resetN(resetN), .RGBIn(RGBIn), .testPattern(testPattern),
    .pixelX(pixelX), .pixelY(pixelY), .startOfFrame(startOfFrame),
    .frameCounter(frameCounter), .hsync(hsync), .vsync(vsync), .blankN(blankN),
    .red(red), .green(green), .blue(blue)
  );

  typedef struct {
    int         k;
    logic       hs, vs, bl;
    logic [7:0] r, g, b;
  } vec_t;

  vec_t vecs[$];
  vec_t tvecs[$];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t mk(int k, bit hs, bit vs, bit bl,
                              logic [7:0] r, logic [7:0] g, logic [7:0] b);
    vec_t v;
    v.k = k; v.hs = hs; v.vs = vs; v.bl = bl; v.r = r; v.g = g; v.b = b;
    return v;
  endfunction

  function automatic logic [65:0] pack(logic [10:0] x, logic [10:0] y, logic sof,
                                       logic [15:0] fc, vec_t v);
    return {x, y, sof, fc, v.hs, v.vs, v.bl, v.r, v.g, v.b};
  endfunction

  // Coordinates follow directly from cycles since reset release.
  function automatic logic [65:0] exp_at(int k, vec_t v);
    int x, y;
    x = k % HT;
    y = (k / HT) % VT;
    return pack(11'(x), 11'(y), (x == 0 && y == 0), 16'(k / (HT * VT)), v);
  endfunction

  // RGBIn schedule by cycle for the main table.
  function automatic logic [7:0] rgb_at(int k);
    if (k == 79) return 8'hE0;
    if (k >= 100 && k <= 124) return 8'hFF;
    if (k >= 125 && k <= 130) return 8'h5A;
    if (k >= 131 && k <= 134) return 8'h1F;
    if (k >= 135 && k <= 299) return 8'hFF;
    return 8'h00;
  endfunction

  task automatic check(string name, int k, logic [65:0] exp);
    vec_t a;
    logic [65:0] got;
    a = mk(0, hsync, vsync, blankN, red, green, blue);
    got = pack(pixelX, pixelY, startOfFrame, frameCounter, a);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s k=%0d got x=%0d y=%0d sof=%b fc=%0d hs=%b vs=%b bl=%b rgb=%h%h%h",
               name, k, got[65:55], got[54:44], got[43], got[42:27], got[26], got[25],
               got[24], got[23:16], got[15:8], got[7:0]);
      $display("     %s k=%0d required x=%0d y=%0d sof=%b fc=%0d hs=%b vs=%b bl=%b rgb=%h%h%h",
               name, k, exp[65:55], exp[54:44], exp[43], exp[42:27], exp[26], exp[25],
               exp[24], exp[23:16], exp[15:8], exp[7:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t rst_v;
  int   idx;

  initial begin
    rst_v = mk(0, 1, 1, 0, 8'h00, 8'h00, 8'h00);

    // Output-stage expectations: {cycle, hsync, vsync, blankN, red, green, blue}
    vecs.push_back(mk(0,   1, 1, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(1,   1, 1, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(2,   1, 1, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(3,   1, 1, 1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(18,  1, 1, 1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(19,  1, 1, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(20,  1, 1, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(21,  0, 1, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(23,  0, 1, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(24,  1, 1, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(79,  1, 1, 1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(80,  1, 1, 1, 8'hFF, 8'h00, 8'h00));
    vecs.push_back(mk(81,  1, 1, 1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(110, 1, 1, 1, 8'hFF, 8'hFF, 8'hFF));
    vecs.push_back(mk(114, 1, 1, 1, 8'hFF, 8'hFF, 8'hFF));
    vecs.push_back(mk(115, 1, 1, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(116, 1, 1, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(118, 0, 1, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(120, 1, 1, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(128, 1, 1, 1, 8'h49, 8'hDB, 8'hAA));
    vecs.push_back(mk(133, 1, 1, 1, 8'h00, 8'hFF, 8'hFF));
    vecs.push_back(mk(150, 1, 1, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(170, 1, 1, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(171, 1, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(174, 1, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(218, 1, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(219, 1, 1, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(239, 0, 1, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(240, 1, 1, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(241, 1, 1, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(243, 1, 1, 1, 8'hFF, 8'hFF, 8'hFF));

    // Test-pattern bars are two pixels wide on this raster.
    tvecs.push_back(mk(3,  1, 1, 1, 8'hFF, 8'hFF, 8'hFF));
    tvecs.push_back(mk(4,  1, 1, 1, 8'hFF, 8'hFF, 8'hFF));
    tvecs.push_back(mk(5,  1, 1, 1, 8'hFF, 8'hFF, 8'h00));
    tvecs.push_back(mk(7,  1, 1, 1, 8'h00, 8'hFF, 8'hFF));
    tvecs.push_back(mk(9,  1, 1, 1, 8'h00, 8'hFF, 8'h00));
    tvecs.push_back(mk(11, 1, 1, 1, 8'hFF, 8'h00, 8'hFF));
    tvecs.push_back(mk(17, 1, 1, 1, 8'h00, 8'h00, 8'h00));
    tvecs.push_back(mk(19, 1, 1, 0, 8'h00, 8'h00, 8'h00));

    resetN      = 1'b0;
    RGBIn       = 8'h00;
    testPattern = TpTable;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", 0, pack(11'd0, 11'd0, 1'b0, 16'd0, rst_v));

    @(negedge clk);
    resetN = 1'b1;
    #1;
    idx = 0;
    for (int k = 0; k <= 243; k++) begin
      RGBIn = rgb_at(k);
      while (idx < vecs.size() && vecs[idx].k == k) begin
        check("table", k, exp_at(k, vecs[idx]));
        idx++;
      end
      if (k < 243) step();
    end

    // Run into the hsync pulse of frame 1, then reset mid-pulse.
    for (int k = 244; k <= 262; k++) begin
      step();
      RGBIn = rgb_at(k);
    end
    check("pre_reset", 262, exp_at(262, mk(262, 0, 1, 0, 8'h00, 8'h00, 8'h00)));
    #2;
    resetN = 1'b0;
    #1;
    check("async_reset", 262, pack(11'd0, 11'd0, 1'b0, 16'd0, rst_v));
    RGBIn = 8'h03;
    repeat (3) @(posedge clk);
    #1;
    check("reset_held", 262, pack(11'd0, 11'd0, 1'b0, 16'd0, rst_v));
    @(negedge clk);
    resetN = 1'b1;
    #1;
    check("restart", 0, exp_at(0, rst_v));
    step();
    check("restart", 1, exp_at(1, rst_v));
    step();
    step();
    check("restart", 3, exp_at(3, mk(3, 1, 1, 1, 8'h00, 8'h00, 8'hFF)));

`ifdef VGA_TEST_PATTERN_EN
    testPattern = 1'b1;
    RGBIn       = 8'h00;
    resetN      = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    resetN = 1'b1;
    #1;
    idx = 0;
    for (int k = 0; k <= 19; k++) begin
      while (idx < tvecs.size() && tvecs[idx].k == k) begin
        check("pattern", k, exp_at(k, tvecs[idx]));
        idx++;
      end
      if (k < 19) step();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
